// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and default timing for every button event block
package btn_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_t;
  localparam int LONG_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/btn_event_hold_timer.sv
// hold_timer: terminal-count counter with selectable long/repeat limit
module hold_timer
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic sel_long,
  output logic tc
);
  localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d, limit;
  always_comb begin
    limit = sel_long ? CNT_W'(LONG_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);
    tc    = en && (cnt_q == limit);
    cnt_d = (clr || tc) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into press/release/long-press/repeat pulses
module btn_event
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_clean,
  output logic       press,
  output logic       release_evt,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       held,
  output logic [7:0] press_count
);
  state_t     state_q, state_d;
  logic       armed_q, armed_d;
  logic       press_q, press_d, rel_q, rel_d, long_q, long_d, rpt_q, rpt_d, held_q, held_d;
  logic [7:0] cnt_q, cnt_d;
  logic       active, tc;
  assign active = (state_q == PRESS) || (state_q == REPEAT);
  hold_timer #(.LONG_CYCLES(LONG_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!(active && btn_clean)),
    .en       (active && btn_clean),
    .sel_long (state_q == PRESS),
    .tc       (tc)
  );
  // release is checked before tc so a drop on the terminal edge suppresses the event
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~btn_clean;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (armed_q && btn_clean) begin
        state_d = PRESS;
        press_d = 1'b1;
        cnt_d   = cnt_q + 8'd1;
      end
      PRESS: if (!btn_clean) begin
        state_d = IDLE;
        rel_d   = 1'b1;
      end else if (tc) begin
        state_d = REPEAT;
        long_d  = 1'b1;
      end
      REPEAT: if (!btn_clean) begin
        state_d = IDLE;
        rel_d   = 1'b1;
      end else rpt_d = tc;
      default: state_d = IDLE;
    endcase
    held_d = (state_d == PRESS) || (state_d == REPEAT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end
  assign press       = press_q;
  assign release_evt = rel_q;
  assign long_press  = long_q;
  assign repeat_evt  = rpt_q;
  assign held        = held_q;
  assign press_count = cnt_q;
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed vector table plus hand sequences for btn_event (LONG=8, REPEAT=4)
module tb_btn_event;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       press, release_evt, long_press, repeat_evt, held;
  logic [7:0] press_count;
  int         total = 0;
  int         bad = 0;
  typedef struct {
    logic       btn;
    logic [4:0] exp;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[$];
  btn_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_clean   (btn),
    .press       (press),
    .release_evt (release_evt),
    .long_press  (long_press),
    .repeat_evt  (repeat_evt),
    .held        (held),
    .press_count (press_count)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] outs();
    return {press, release_evt, long_press, repeat_evt, held};
  endfunction
  function automatic void add(input logic b, input logic [4:0] e, input logic [7:0] c);
    vec_t v;
    v.btn = b;
    v.exp = e;
    v.cnt = c;
    vecs.push_back(v);
  endfunction
  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic chk_idle(input string name, input logic [7:0] c);
    chk({name, "_outs"}, 32'(outs()), 32'd0);
    chk({name, "_cnt"}, 32'(press_count), 32'(c));
  endtask
  initial begin
    int n;
    // outputs are {press, release, long_press, repeat, held}
    for (int i = 1; i <= 9; i++) add(1'b0, 5'b00000, 8'd0);
    add(1'b1, 5'b10001, 8'd1);
    add(1'b1, 5'b00001, 8'd1);
    add(1'b1, 5'b00001, 8'd1);
    add(1'b0, 5'b01000, 8'd1);
    add(1'b0, 5'b00000, 8'd1);
    add(1'b0, 5'b00000, 8'd1);
    for (int i = 0; i <= 20; i++)
      add(1'b1, {i == 0, 1'b0, i == 8, i == 12 || i == 16 || i == 20, 1'b1}, 8'd2);
    add(1'b0, 5'b01000, 8'd2);
    add(1'b0, 5'b00000, 8'd2);
    for (int i = 0; i <= 7; i++) add(1'b1, {i == 0, 3'b000, 1'b1}, 8'd3);
    add(1'b0, 5'b01000, 8'd3);
    add(1'b0, 5'b00000, 8'd3);
    add(1'b1, 5'b10001, 8'd4);
    add(1'b0, 5'b01000, 8'd4);
    add(1'b0, 5'b00000, 8'd4);
    #12;
    chk_idle("reset", 8'd0);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].btn);
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(press_count), 32'(vecs[i].cnt));
    end
    #2 rst_n = 1'b0;
    btn = 1'b1;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      chk_idle($sformatf("thru_reset%0d", i), 8'd0);
    end
    step(1'b0);
    chk_idle("thru_reset_drop", 8'd0);
    step(1'b1);
    chk("thru_reset_press", 32'(outs()), 32'b10001);
    chk("thru_reset_cnt", 32'(press_count), 32'd1);
    step(1'b0);
    chk("thru_reset_rel", 32'(outs()), 32'b01000);
    #2 rst_n = 1'b0;
    btn = 1'b0;
    #3 rst_n = 1'b1;
    step(1'b0);
    n = 0;
    for (int t = 0; t < 256; t++) begin
      step(1'b1);
      n += int'(press);
      step(1'b1);
      n += int'(press);
      step(1'b0);
      step(1'b0);
      if (t == 127) chk("wrap_mid_cnt", 32'(press_count), 32'd128);
    end
    chk("wrap_presses", 32'(n), 32'd256);
    chk("wrap_cnt", 32'(press_count), 32'd0);
    step(1'b1);
    chk("repeat_entry_press", 32'(outs()), 32'b10001);
    for (int i = 1; i <= 9; i++) step(1'b1);
    chk("repeat_state", 32'(dut.state_q), 32'd2);
    chk("repeat_held", 32'(held), 32'd1);
    chk("repeat_cnt_pre", 32'(press_count), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("async_rst", 8'd0);
    chk("async_rst_timer", 32'(dut.u_timer.cnt_q), 32'd0);
    chk("async_rst_state", 32'(dut.state_q), 32'd0);
    @(posedge clk);
    #1;
    chk_idle("async_rst_hold", 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      chk_idle($sformatf("post_rst%0d", i), 8'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
